branch_predictor_gshare: RTL and testbench

// Parametrised dynamic branch predictor for the 5-stage RISC-V pipeline; replaces the fixed 1024-entry bimodal predictor.
// IF-stage lookup: a pattern history table (PHT) of 2-bit counters, indexed bimodal or gshare, plus a direct-mapped

---
 rtl/branch_predictor_gshare_if.sv | 41 ++++
 rtl/branch_predictor_gshare.sv | 161 ++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_gshare_if.sv
// rtl/branch_predictor_gshare_if.sv - lookup and resolution bundle for the gshare branch predictor
//
// Signals:
//   if_valid, if_pc                  IF-stage lookup request and fetch PC
//   pred_hit, pred_taken,            combinational prediction for if_pc
//   pred_target, pred_ghr
//   upd_valid, upd_pc, upd_cond,     resolved control transfer from MEM
//   upd_taken, upd_target,
//   upd_ghr, upd_mispred
// Modports: master = core side, slave = predictor side.

interface branch_predictor_gshare_if #(
  parameter int DATA_WIDTH = 32,
  parameter int GHR_BITS   = 8
);
  logic                  if_valid;
  logic [DATA_WIDTH-1:0] if_pc;
  logic                  pred_hit;
  logic                  pred_taken;
  logic [DATA_WIDTH-1:0] pred_target;
  logic [GHR_BITS-1:0]   pred_ghr;
  logic                  upd_valid;
  logic [DATA_WIDTH-1:0] upd_pc;
  logic                  upd_cond;
  logic                  upd_taken;
  logic [DATA_WIDTH-1:0] upd_target;
  logic [GHR_BITS-1:0]   upd_ghr;
  logic                  upd_mispred;

  modport master (
    output if_valid, if_pc,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
    output upd_valid, upd_pc, upd_cond, upd_taken, upd_target, upd_ghr, upd_mispred
  );

  modport slave (
    input  if_valid, if_pc,
    output pred_hit, pred_taken, pred_target, pred_ghr,
    input  upd_valid, upd_pc, upd_cond, upd_taken, upd_target, upd_ghr, upd_mispred
  );
endinterface

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - bimodal/gshare PHT plus direct-mapped BTB with speculative global history
//
// Ports:
//   clk              clock
//   rst              synchronous active-high reset; restarts the table init sweep
//   bp               slave side of branch_predictor_gshare_if (lookup + resolution)
//   ready_o          high once the init sweep has finished
//   perf_branches_o  accepted resolution count (wraps)
//   perf_mispred_o   accepted mispredict count (wraps)

module branch_predictor_gshare #(
  parameter int DATA_WIDTH = 32,
  parameter int PHT_BITS   = 10,
  parameter int GHR_BITS   = 8,
  parameter int BTB_BITS   = 6,
  parameter int MODE       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_predictor_gshare_if.slave bp,
  output logic                     ready_o,
  output logic [31:0]              perf_branches_o,
  output logic [31:0]              perf_mispred_o
);

  localparam int PHT_N    = 1 << PHT_BITS;
  localparam int BTB_N    = 1 << BTB_BITS;
  localparam int PTR_BITS = (PHT_BITS > BTB_BITS) ? PHT_BITS : BTB_BITS;
  localparam int TAG_BITS = DATA_WIDTH - BTB_BITS - 2;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t                state_q, state_d;
  logic [PTR_BITS-1:0]   ptr_q, ptr_d;
  logic [GHR_BITS-1:0]   ghr_q, ghr_d;
  logic [31:0]           perf_br_q, perf_mp_q;

  logic [1:0]            pht_q        [PHT_N];
  logic                  btb_valid_q  [BTB_N];
  logic [TAG_BITS-1:0]   btb_tag_q    [BTB_N];
  logic [DATA_WIDTH-1:0] btb_target_q [BTB_N];
  logic                  btb_jump_q   [BTB_N];

  logic                  ready;
  logic [PHT_BITS-1:0]   if_pht_idx, upd_pht_idx;
  logic [BTB_BITS-1:0]   if_btb_idx, upd_btb_idx;
  logic [TAG_BITS-1:0]   if_tag, upd_tag;
  logic [DATA_WIDTH-1:0] if_pc_plus4;
  logic                  hit, taken;
  logic [DATA_WIDTH-1:0] target;
  logic                  upd_accept;
  logic [1:0]            ctr_old, ctr_new;

  // Bimodal mode ignores history entirely; gshare folds the zero-extended GHR into the low index bits.
  assign if_pht_idx  = bp.if_pc[PHT_BITS+1:2]  ^ ((MODE != 0) ? PHT_BITS'(ghr_q)      : '0);
  assign upd_pht_idx = bp.upd_pc[PHT_BITS+1:2] ^ ((MODE != 0) ? PHT_BITS'(bp.upd_ghr) : '0);
  assign if_btb_idx  = bp.if_pc[BTB_BITS+1:2];
  assign upd_btb_idx = bp.upd_pc[BTB_BITS+1:2];
  assign if_tag      = bp.if_pc[DATA_WIDTH-1:BTB_BITS+2];
  assign upd_tag     = bp.upd_pc[DATA_WIDTH-1:BTB_BITS+2];
  assign if_pc_plus4 = bp.if_pc + DATA_WIDTH'(4);
  assign upd_accept  = bp.upd_valid & ready;

  // Lookup reads the registered tables directly, so a same-cycle update is not visible yet.
  always_comb begin
    hit    = 1'b0;
    taken  = 1'b0;
    target = if_pc_plus4;
    if (ready) begin
      hit = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
      if (hit) begin
        taken = btb_jump_q[if_btb_idx] ? 1'b1 : pht_q[if_pht_idx][1];
        if (taken) target = btb_target_q[if_btb_idx];
      end
    end
  end

  assign bp.pred_hit    = hit;
  assign bp.pred_taken  = taken;
  assign bp.pred_target = target;
  assign bp.pred_ghr    = ghr_q;

  assign ctr_old = pht_q[upd_pht_idx];
  always_comb begin
    ctr_new = ctr_old;
    if (bp.upd_taken) begin
      if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
    end else begin
      if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
    end
  end

  // Mispredict recovery takes priority over the speculative shift of the same cycle.
  always_comb begin
    ghr_d = ghr_q;
    if (upd_accept && bp.upd_mispred) begin
      ghr_d = bp.upd_cond ? {bp.upd_ghr[GHR_BITS-2:0], bp.upd_taken} : bp.upd_ghr;
    end else if (bp.if_valid && ready && hit && !btb_jump_q[if_btb_idx]) begin
      ghr_d = {ghr_q[GHR_BITS-2:0], taken};
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready   = 1'b0;
    case (state_q)
      S_INIT: begin
        ptr_d = ptr_q + PTR_BITS'(1);
        if (ptr_q == '1) state_d = S_RUN;
      end
      S_RUN:   ready = 1'b1;
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q     <= '0;
      perf_br_q <= '0;
      perf_mp_q <= '0;
    end else begin
      ghr_q <= ghr_d;
      if (upd_accept) begin
        perf_br_q <= perf_br_q + 32'd1;
        if (bp.upd_mispred) perf_mp_q <= perf_mp_q + 32'd1;
      end
    end
  end

  // The sweep pointer spans the larger table; the smaller one simply sees its entries cleared repeatedly.
  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      pht_q[ptr_q[PHT_BITS-1:0]]       <= 2'b01;
      btb_valid_q[ptr_q[BTB_BITS-1:0]] <= 1'b0;
    end else if (upd_accept) begin
      if (bp.upd_cond) pht_q[upd_pht_idx] <= ctr_new;
      if (bp.upd_taken) begin
        btb_valid_q[upd_btb_idx]  <= 1'b1;
        btb_tag_q[upd_btb_idx]    <= upd_tag;
        btb_target_q[upd_btb_idx] <= bp.upd_target;
        btb_jump_q[upd_btb_idx]   <= ~bp.upd_cond;
      end
    end
  end

  assign ready_o         = ready;
  assign perf_branches_o = perf_br_q;
  assign perf_mispred_o  = perf_mp_q;

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - directed table-driven bench for branch_predictor_gshare

module tb_branch_predictor_gshare;

  logic        clk;
  logic        rst;
  logic        ready0, ready1;
  logic [31:0] perf_br0, perf_mp0, perf_br1, perf_mp1;
  int          checks;
  int          failures;

  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_BITS(8)) bp0 ();
  branch_predictor_gshare_if #(.DATA_WIDTH(32), .GHR_BITS(8)) bp1 ();

  branch_predictor_gshare #(.DATA_WIDTH(32), .PHT_BITS(10), .GHR_BITS(8), .BTB_BITS(6), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bp(bp0.slave),
    .ready_o(ready0), .perf_branches_o(perf_br0), .perf_mispred_o(perf_mp0)
  );

  branch_predictor_gshare #(.DATA_WIDTH(32), .PHT_BITS(10), .GHR_BITS(8), .BTB_BITS(6), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bp(bp1.slave),
    .ready_o(ready1), .perf_branches_o(perf_br1), .perf_mispred_o(perf_mp1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        do_upd;
    logic [31:0] upd_pc;
    logic        cond;
    logic        taken;
    logic [31:0] tgt;
    logic [31:0] look_pc;
    logic        exp_hit;
    logic        exp_taken;
    logic [31:0] exp_target;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic upd0(input logic [31:0] pc, input logic cond, input logic taken,
                      input logic [31:0] tgt, input logic mispred, input logic [7:0] ghr);
    bp0.upd_valid   = 1'b1;
    bp0.upd_pc      = pc;
    bp0.upd_cond    = cond;
    bp0.upd_taken   = taken;
    bp0.upd_target  = tgt;
    bp0.upd_mispred = mispred;
    bp0.upd_ghr     = ghr;
    @(posedge clk);
    #1;
    bp0.upd_valid   = 1'b0;
    bp0.upd_mispred = 1'b0;
  endtask

  task automatic upd1(input logic [31:0] pc, input logic cond, input logic taken,
                      input logic [31:0] tgt, input logic mispred, input logic [7:0] ghr);
    bp1.upd_valid   = 1'b1;
    bp1.upd_pc      = pc;
    bp1.upd_cond    = cond;
    bp1.upd_taken   = taken;
    bp1.upd_target  = tgt;
    bp1.upd_mispred = mispred;
    bp1.upd_ghr     = ghr;
    @(posedge clk);
    #1;
    bp1.upd_valid   = 1'b0;
    bp1.upd_mispred = 1'b0;
  endtask

  task automatic wait_sweep(input string name);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (cnt == 5) begin
        chk({name, "_busy_ready"}, {31'd0, ready0}, 32'd0);
        chk({name, "_busy_hit"}, {31'd0, bp0.pred_hit}, 32'd0);
        chk({name, "_busy_target"}, bp0.pred_target, bp0.if_pc + 32'd4);
      end
      if (ready0) break;
    end
    chk({name, "_cycles"}, cnt, 32'd1024);
    chk({name, "_ready1"}, {31'd0, ready1}, 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    //            upd  upd_pc        c  t  tgt           look_pc      hit tk target
    vecs[0]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,   32'h100, 1'b0, 1'b0, 32'h104};
    vecs[1]  = '{1'b1, 32'h200,    1'b1, 1'b1, 32'h180, 32'h200, 1'b1, 1'b1, 32'h180};
    vecs[2]  = '{1'b1, 32'h200,    1'b1, 1'b1, 32'h180, 32'h200, 1'b1, 1'b1, 32'h180};
    vecs[3]  = '{1'b1, 32'h200,    1'b1, 1'b0, 32'h180, 32'h200, 1'b1, 1'b1, 32'h180};
    vecs[4]  = '{1'b1, 32'h200,    1'b1, 1'b0, 32'h180, 32'h200, 1'b1, 1'b0, 32'h204};
    vecs[5]  = '{1'b1, 32'h200,    1'b1, 1'b0, 32'h180, 32'h200, 1'b1, 1'b0, 32'h204};
    vecs[6]  = '{1'b1, 32'h300,    1'b0, 1'b1, 32'h400, 32'h300, 1'b1, 1'b1, 32'h400};
    vecs[7]  = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,   32'h200, 1'b0, 1'b0, 32'h204};
    vecs[8]  = '{1'b1, 32'h240,    1'b1, 1'b1, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[9]  = '{1'b1, 32'h240,    1'b1, 1'b1, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[10] = '{1'b1, 32'h240,    1'b1, 1'b1, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[11] = '{1'b1, 32'h240,    1'b1, 1'b1, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[12] = '{1'b1, 32'h240,    1'b1, 1'b1, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[13] = '{1'b1, 32'h240,    1'b1, 1'b0, 32'h280, 32'h240, 1'b1, 1'b1, 32'h280};
    vecs[14] = '{1'b0, 32'h0,      1'b0, 1'b0, 32'h0,   32'h244, 1'b0, 1'b0, 32'h248};

    rst = 1'b1;
    bp0.if_valid = 1'b0; bp0.if_pc = 32'h100;
    bp0.upd_valid = 1'b0; bp0.upd_pc = '0; bp0.upd_cond = 1'b0; bp0.upd_taken = 1'b0;
    bp0.upd_target = '0; bp0.upd_ghr = '0; bp0.upd_mispred = 1'b0;
    bp1.if_valid = 1'b0; bp1.if_pc = 32'h0;
    bp1.upd_valid = 1'b0; bp1.upd_pc = '0; bp1.upd_cond = 1'b0; bp1.upd_taken = 1'b0;
    bp1.upd_target = '0; bp1.upd_ghr = '0; bp1.upd_mispred = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, ready0}, 32'd0);
    chk("rst_ghr", {24'd0, bp0.pred_ghr}, 32'd0);
    chk("rst_perf_br", perf_br0, 32'd0);
    rst = 1'b0;
    wait_sweep("sweep1");

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].do_upd)
        upd0(vecs[i].upd_pc, vecs[i].cond, vecs[i].taken, vecs[i].tgt, 1'b0, 8'h00);
      bp0.if_valid = 1'b0;
      bp0.if_pc    = vecs[i].look_pc;
      #1;
      chk($sformatf("v%0d_hit", i), {31'd0, bp0.pred_hit}, {31'd0, vecs[i].exp_hit});
      chk($sformatf("v%0d_taken", i), {31'd0, bp0.pred_taken}, {31'd0, vecs[i].exp_taken});
      chk($sformatf("v%0d_target", i), bp0.pred_target, vecs[i].exp_target);
    end
    chk("tbl_perf_br", perf_br0, 32'd12);
    chk("tbl_perf_mp", perf_mp0, 32'd0);

    // JAL hit leaves history alone; a taken conditional hit shifts in a 1.
    bp0.if_valid = 1'b1;
    bp0.if_pc    = 32'h300;
    @(posedge clk); #1;
    chk("jal_ghr_hold", {24'd0, bp0.pred_ghr}, 32'h00);
    bp0.if_pc = 32'h240;
    @(posedge clk); #1;
    chk("cond_ghr_shift", {24'd0, bp0.pred_ghr}, 32'h01);
    bp0.if_valid = 1'b0;

    // gshare: recovery overrides the speculative shift.
    upd1(32'h500, 1'b1, 1'b1, 32'h600, 1'b0, 8'h00);
    bp1.if_pc = 32'h500;
    #1;
    chk("g_hit", {31'd0, bp1.pred_hit}, 32'd1);
    chk("g_taken", {31'd0, bp1.pred_taken}, 32'd1);
    chk("g_target", bp1.pred_target, 32'h600);
    upd1(32'h704, 1'b0, 1'b1, 32'h800, 1'b1, 8'h05);
    chk("g_ghr_set", {24'd0, bp1.pred_ghr}, 32'h05);
    bp1.if_valid = 1'b1;
    bp1.if_pc    = 32'h500;
    #1;
    chk("g_same_cycle_hit", {31'd0, bp1.pred_hit}, 32'd1);
    chk("g_hist_idx_taken", {31'd0, bp1.pred_taken}, 32'd0);
    upd1(32'h504, 1'b1, 1'b1, 32'h900, 1'b1, 8'h3A);
    chk("g_recover", {24'd0, bp1.pred_ghr}, 32'h75);
    chk("g_spec_taken", {31'd0, bp1.pred_taken}, 32'd0);
    @(posedge clk); #1;
    chk("g_spec_shift", {24'd0, bp1.pred_ghr}, 32'hEA);
    bp1.if_valid = 1'b0;

    // Three mispredicts, then a reset pulse mid-run.
    for (int j = 0; j < 3; j++) upd0(32'h600, 1'b1, 1'b0, 32'h0, 1'b1, 8'h00);
    chk("mp_count", perf_mp0, 32'd3);
    chk("br_count", perf_br0, 32'd15);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst2_ready", {31'd0, ready0}, 32'd0);
    chk("rst2_mp", perf_mp0, 32'd0);
    chk("rst2_br", perf_br0, 32'd0);
    chk("rst2_ghr", {24'd0, bp0.pred_ghr}, 32'd0);
    wait_sweep("sweep2");
    bp0.if_pc = 32'h240;
    #1;
    chk("post_hit", {31'd0, bp0.pred_hit}, 32'd0);
    chk("post_target", bp0.pred_target, 32'h244);
    bp0.if_pc = 32'h300;
    #1;
    chk("post_jal_hit", {31'd0, bp0.pred_hit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
